// File: rtl/cronometro_bcd_pkg.sv
// cronometro_pkg: shared state encoding, BCD digit type and preset clamp for the BCD countdown timer.
package cronometro_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  // Lower digits saturate at 9, the most significant digit at msd_max; digits past `digits` are zero.
  function automatic logic [31:0] clamp_bcd(input logic [31:0] v, input int digits, input int msd_max);
    bcd_t lim;
    clamp_bcd = '0;
    for (int i = 0; i < 8; i++) begin
      lim = (i == digits - 1) ? bcd_t'(msd_max) : BCD_MAX;
      if (i < digits) clamp_bcd[4*i+:4] = (v[4*i+:4] > lim) ? lim : v[4*i+:4];
    end
  endfunction
endpackage

// File: rtl/cronometro_bcd_if.sv
// cronometro_bcd_if: control, preset and status bundle of the BCD countdown timer.
interface cronometro_bcd_if #(parameter int DIGITS = 2);
  logic                  tick;
  logic                  load;
  logic                  run;
  logic                  auto_reload;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   alert_val;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  alert;
  logic                  expire;
  logic                  busy;
  modport master (output tick, load, run, auto_reload, preset, alert_val,
                  input  count, zero, alert, expire, busy);
  modport slave  (input  tick, load, run, auto_reload, preset, alert_val,
                  output count, zero, alert, expire, busy);
endinterface

// File: rtl/cronometro_bcd_digit_down.sv
// bcd_digit_down: one loadable BCD digit that decrements on borrow-in and wraps 0 to 9.
module bcd_digit_down
  import cronometro_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic dec_i,
  input  logic borrow_i,
  output logic borrow_o,
  output bcd_t value_o
);
  bcd_t value_q, value_d;
  always_comb value_d = load_i ? load_val_i :
                        (dec_i && borrow_i) ? ((value_q == '0) ? BCD_MAX : value_q - 4'd1) : value_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value_q <= '0;
    else value_q <= value_d;
  assign borrow_o = borrow_i && (value_q == '0);
  assign value_o  = value_q;
endmodule

// File: rtl/cronometro_bcd.sv
// cronometro_bcd: multi-digit BCD countdown timer with clamped preset, alert compare and auto-reload.
module cronometro_bcd
  import cronometro_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MSD_MAX = 3
)(
  input logic clock,
  input logic reset_n,
  cronometro_bcd_if.slave bus
);
  localparam int W = 4 * DIGITS;
  state_e         state_q;
  logic           expire_q;
  logic [W-1:0]   count, preset_c;
  logic [DIGITS:0] borrow;
  logic           at_zero, at_one, step, reload;
  assign preset_c = W'(clamp_bcd(32'(bus.preset), DIGITS, MSD_MAX));
  // With borrow[0] tied high the chain's carry-out is exactly "all digits zero".
  assign borrow[0] = 1'b1;
  assign at_zero   = borrow[DIGITS];
  assign at_one    = (count == W'(1));
  assign step      = (state_q == RUN) && bus.run && bus.tick;
  assign reload    = bus.load || (step && at_zero);
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_down u_dig (
      .clk        (clock),
      .rst_n      (reset_n),
      .load_i     (reload),
      .load_val_i (preset_c[4*g+:4]),
      .dec_i      (step && !at_zero),
      .borrow_i   (borrow[g]),
      .borrow_o   (borrow[g+1]),
      .value_o    (count[4*g+:4])
    );
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      expire_q <= 1'b0;
    end else if (bus.load) begin
      state_q  <= IDLE;
      expire_q <= 1'b0;
    end else begin
      expire_q <= step && at_one;
      case (state_q)
        IDLE: if (bus.run && !at_zero) state_q <= RUN;
        RUN:
          if (!bus.run) state_q <= IDLE;
          else if (bus.tick && at_one && !bus.auto_reload) state_q <= DONE;
          else if (bus.tick && at_zero && preset_c == '0) state_q <= IDLE;
        default: state_q <= state_q;
      endcase
    end
  assign bus.count  = count;
  assign bus.zero   = at_zero;
  assign bus.alert  = (count == bus.alert_val);
  assign bus.expire = expire_q;
  assign bus.busy   = (state_q == RUN);
endmodule

// File: tb/tb_cronometro_bcd.sv
// tb_cronometro_bcd: directed self-checking bench for the two-digit BCD countdown timer.
module tb_cronometro_bcd;
  logic clock = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  cronometro_bcd_if #(.DIGITS(2)) bus ();
  cronometro_bcd #(.DIGITS(2), .MSD_MAX(3)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int k);
    bcd2 = {4'(k / 10), 4'(k % 10)};
  endfunction

  task automatic do_load(input logic [7:0] p);
    bus.preset = p;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.tick = 0; bus.load = 0; bus.run = 0; bus.auto_reload = 0;
    bus.preset = '0; bus.alert_val = 8'hFF;
    repeat (2) cyc();
    checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", bus.count); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.expire !== 1'b0) begin errors++; $display("FAIL reset_expire got %b exp 0", bus.expire); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_countdown();
    bus.auto_reload = 0;
    do_load(8'h25);
    checks++; if (bus.count !== 8'h25) begin errors++; $display("FAIL cd_load got %h exp 25", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cd_idle_busy got %b exp 0", bus.busy); end
    bus.run = 1;
    cyc();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cd_run_busy got %b exp 1", bus.busy); end
    for (int k = 24; k >= 0; k--) begin
      do_tick();
      checks++; if (bus.count !== bcd2(k)) begin errors++; $display("FAIL cd_count got %h exp %h", bus.count, bcd2(k)); end
      checks++; if (bus.expire !== (k == 0)) begin errors++; $display("FAIL cd_expire at %0d got %b exp %b", k, bus.expire, k == 0); end
      cyc();
      checks++; if (bus.expire !== 1'b0) begin errors++; $display("FAIL cd_expire_gap at %0d got %b exp 0", k, bus.expire); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cd_done_busy got %b exp 0", bus.busy); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL cd_done_zero got %b exp 1", bus.zero); end
    do_tick();
    checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL cd_done_hold got %h/%b exp 00/0", bus.count, bus.busy); end
    bus.run = 0;
  endtask

  task automatic test_auto_reload();
    logic [7:0] e;
    bus.auto_reload = 1;
    do_load(8'h05);
    bus.run = 1;
    cyc();
    for (int t = 1; t <= 12; t++) begin
      e = (t <= 5) ? bcd2(5 - t) : (t <= 11) ? bcd2(11 - t) : 8'h05;
      do_tick();
      checks++; if (bus.count !== e) begin errors++; $display("FAIL ar_count tick %0d got %h exp %h", t, bus.count, e); end
      checks++; if (bus.expire !== (t == 5 || t == 11)) begin errors++; $display("FAIL ar_expire tick %0d got %b", t, bus.expire); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ar_busy tick %0d got %b exp 1", t, bus.busy); end
      cyc();
    end
    bus.run = 0; bus.auto_reload = 0;
    cyc();
  endtask

  task automatic test_clamp_alert();
    do_load(8'hFF);
    checks++; if (bus.count !== 8'h39) begin errors++; $display("FAIL clamp_ff got %h exp 39", bus.count); end
    do_load(8'h4C);
    checks++; if (bus.count !== 8'h39) begin errors++; $display("FAIL clamp_4c got %h exp 39", bus.count); end
    do_load(8'h2B);
    checks++; if (bus.count !== 8'h29) begin errors++; $display("FAIL clamp_2b got %h exp 29", bus.count); end
    do_load(8'hFF);
    bus.alert_val = 8'h15;
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL alert_at39 got %b exp 0", bus.alert); end
    bus.run = 1;
    cyc();
    for (int k = 38; k >= 10; k--) begin
      do_tick();
      checks++; if (bus.count !== bcd2(k)) begin errors++; $display("FAIL alert_count got %h exp %h", bus.count, bcd2(k)); end
      checks++; if (bus.alert !== (k == 15)) begin errors++; $display("FAIL alert at %0d got %b exp %b", k, bus.alert, k == 15); end
    end
    bus.run = 0; bus.alert_val = 8'hFF;
    cyc();
  endtask

  task automatic test_load_priority();
    do_load(8'h07);
    bus.run = 1;
    cyc();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL lp_busy got %b exp 1", bus.busy); end
    bus.tick = 1; bus.load = 1;
    cyc();
    bus.tick = 0; bus.load = 0;
    checks++; if (bus.count !== 8'h07) begin errors++; $display("FAIL lp_count got %h exp 07", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lp_idle got %b exp 0", bus.busy); end
    cyc();
    do_tick();
    checks++; if (bus.count !== 8'h06) begin errors++; $display("FAIL lp_resume got %h exp 06", bus.count); end
    bus.run = 0;
    cyc();
  endtask

  task automatic test_pause();
    do_load(8'h12);
    bus.run = 1;
    cyc();
    bus.run = 0;
    do_tick();
    checks++; if (bus.count !== 8'h12 || bus.busy !== 1'b0) begin errors++; $display("FAIL pause_drop got %h/%b exp 12/0", bus.count, bus.busy); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (bus.count !== 8'h12 || bus.busy !== 1'b0) begin errors++; $display("FAIL pause_hold got %h/%b exp 12/0", bus.count, bus.busy); end
    end
    bus.run = 1;
    cyc();
    do_tick();
    checks++; if (bus.count !== 8'h11) begin errors++; $display("FAIL pause_resume got %h exp 11", bus.count); end
    #2 reset_n = 0;
    #1;
    checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst got %h/%b exp 00/0", bus.count, bus.busy); end
    cyc();
    reset_n = 1;
    repeat (2) cyc();
    checks++; if (bus.busy !== 1'b0 || bus.count !== 8'h00) begin errors++; $display("FAIL rst_wait got %h/%b exp 00/0", bus.count, bus.busy); end
    bus.auto_reload = 1;
    do_load(8'h01);
    cyc();
    do_tick();
    checks++; if (bus.expire !== 1'b1) begin errors++; $display("FAIL pre_rst_expire got %b exp 1", bus.expire); end
    #2 reset_n = 0;
    #1;
    checks++; if (bus.expire !== 1'b0 || bus.zero !== 1'b1) begin errors++; $display("FAIL rst_expire got %b/%b exp 0/1", bus.expire, bus.zero); end
    cyc();
    reset_n = 1;
    bus.run = 0; bus.auto_reload = 0;
    cyc();
  endtask

  task automatic test_zero_preset();
    bus.auto_reload = 1;
    do_load(8'h00);
    bus.run = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b0 || bus.expire !== 1'b0) begin errors++; $display("FAIL zp_hold got %h/%b/%b exp 00/0/0", bus.count, bus.busy, bus.expire); end
    end
    do_load(8'h01);
    cyc();
    bus.preset = 8'h00;
    do_tick();
    checks++; if (bus.expire !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL zp_cross got %b/%b exp 1/1", bus.expire, bus.busy); end
    do_tick();
    checks++; if (bus.busy !== 1'b0 || bus.expire !== 1'b0 || bus.count !== 8'h00) begin errors++; $display("FAIL zp_reload got %h/%b/%b exp 00/0/0", bus.count, bus.busy, bus.expire); end
    bus.run = 0;
    cyc();
  endtask

  task automatic test_auto_change();
    bus.auto_reload = 1;
    do_load(8'h02);
    bus.run = 1;
    cyc();
    do_tick();
    bus.auto_reload = 0;
    checks++; if (bus.count !== 8'h01 || bus.busy !== 1'b1) begin errors++; $display("FAIL ac_mid got %h/%b exp 01/1", bus.count, bus.busy); end
    do_tick();
    checks++; if (bus.expire !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'h00) begin errors++; $display("FAIL ac_done got %h/%b/%b exp 00/1/0", bus.count, bus.expire, bus.busy); end
    do_tick();
    checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL ac_hold got %h/%b exp 00/0", bus.count, bus.busy); end
    bus.run = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_auto_reload();
    test_clamp_alert();
    test_load_priority();
    test_pause();
    test_zero_preset();
    test_auto_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
